input_debouncer: RTL
====================

// Module: input_debouncer
// PURPOSE
//   Conditions a raw, asynchronous, bouncy 1-bit input (push-button/switch) into a clean,
//   registered level plus single-cycle edge pulses. Sits directly upstream of the D flip-flop
//   stage: q drives that stage's d input. Provides qbar and a rising-edge event counter.
// PARAMETERS
//   SYNC_STAGES      2   synchronizer flop count on din_raw (>=2)
//   DEBOUNCE_CYCLES  4   consecutive stable synchronized cycles required to commit (>=2)
//   CNT_W            8   width of press_count
// PORTS
//   clk          in   1      single clock; all state changes on posedge clk
//   rst          in   1      asynchronous, active-high reset
//   din_raw      in   1      raw asynchronous input
//   q            out  1      debounced level (registered)
//   qbar         out  1      always ~q (registered)
//   rise         out  1      1-cycle pulse on the cycle q goes 0->1
//   fall         out  1      1-cycle pulse on the cycle q goes 1->0
//   press_count  out  CNT_W  number of committed rising edges, wraps mod 2^CNT_W
// BEHAVIOUR
//   Reset (async, immediate on rst high): sync chain=0, state=S_LOW, cnt=0, q=0, qbar=1,
//     rise=0, fall=0, press_count=0. No pulse is ever generated by reset assert or release.
//   Sync: din_raw -> SYNC_STAGES flops -> din_s. din_s is the only value the FSM samples.
//   FSM (4 states, cnt = debounce counter, width clog2(DEBOUNCE_CYCLES)):
//     S_LOW:       din_s=1 -> S_WAIT_HI, cnt<=1; else stay.
//     S_WAIT_HI:   din_s=0 -> S_LOW, cnt<=0 (abort, no output change).
//                  din_s=1 & cnt<DEBOUNCE_CYCLES-1 -> cnt<=cnt+1.
//                  din_s=1 & cnt==DEBOUNCE_CYCLES-1 -> S_HIGH, q<=1, qbar<=0, rise<=1,
//                  press_count<=press_count+1, cnt<=0.
//     S_HIGH:      din_s=0 -> S_WAIT_LO, cnt<=1; else stay.
//     S_WAIT_LO:   mirror of S_WAIT_HI; commit -> S_LOW, q<=0, qbar<=1, fall<=1.
//   rise/fall are high for exactly one cycle, never both in the same cycle.
//   Latency: din_raw first sampled high at edge 1 and held -> q=1 after edge
//     SYNC_STAGES+DEBOUNCE_CYCLES (defaults: edge 6). Same for falling.
//   Filtering: a din_s excursion shorter than DEBOUNCE_CYCLES cycles produces no change on
//     q, rise, fall or press_count; an excursion of exactly DEBOUNCE_CYCLES commits.
//   Bounce during WAIT restarts from the stable state; counting always restarts at 1.
//   press_count wrap: 2^CNT_W-1 + 1 -> 0, no saturation, no flag.
//   Reset mid-WAIT or mid-pulse: pulse drops immediately, pending commit discarded. After
//     release with din_raw held high, a full fresh debounce occurs: rise fires, count=1.
// STRUCTURE
//   Shared include debounce_defs.vh: state encodings S_LOW=2'd0, S_WAIT_HI=2'd1,
//     S_HIGH=2'd2, S_WAIT_LO=2'd3, reused by later input-conditioning blocks.
//   One sub-module: sync_chain #(.STAGES) (clk, rst, d, q) -- async active-high reset to 0.
//   Top: sync_chain instance + FSM/counter always block + output register block.
// TESTING
//   1. rst=1 then release, din_raw=0 for 20 cycles -> q=0, qbar=1, rise=fall=0, count=0.
//   2. din_raw 0->1 held (defaults) -> q=1 after edge 6, rise high exactly that cycle,
//      press_count=1; then 1->0 held -> fall pulse after 6 edges, q=0, count stays 1.
//   3. Bounce: din_raw high 3 cycles, low 2, high 3, low -> q stays 0, no pulses, count=0.
//   4. CNT_W=2, 5 clean presses -> press_count sequence 1,2,3,0,1.
//   5. din_raw high, rst pulsed during S_WAIT_HI cnt=2 -> outputs reset instantly; after
//      release, rise fires SYNC_STAGES+DEBOUNCE_CYCLES edges later, count=1.
//   6. Exactly DEBOUNCE_CYCLES-wide high pulse on din_s -> commits; one cycle shorter -> none.

Source files
------------

// File: rtl/input_debouncer_pkg.sv
// Shared types for the input-conditioning blocks: debounce FSM states and
// the debounce counter width helper.
package input_debouncer_pkg;

  typedef enum logic [1:0] {
    S_LOW     = 2'd0,
    S_WAIT_HI = 2'd1,
    S_HIGH    = 2'd2,
    S_WAIT_LO = 2'd3
  } deb_state_t;

  // Counter must hold DEBOUNCE_CYCLES-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned cycles);
    return (cycles <= 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/input_debouncer_sync_chain.sv
// Multi-flop synchronizer for an asynchronous 1-bit input; clears to 0 on reset.
module sync_chain #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r <= '0;
    else     r <= {r[STAGES-2:0], d};
  end

  assign q = r[STAGES-1];

endmodule

// File: rtl/input_debouncer.sv
// Debounces a raw bouncy input into a registered level with qbar, one-cycle
// rise/fall pulses and a wrapping count of committed rising edges.
module input_debouncer
  import input_debouncer_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din_raw,
  output logic             q,
  output logic             qbar,
  output logic             rise,
  output logic             fall,
  output logic [CNT_W-1:0] press_count
);

  localparam int unsigned    CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          din_s;
  deb_state_t    state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          commit_rise, commit_fall;

  sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (din_raw),
    .q   (din_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_LOW;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // The first differing sample counts as 1, so a run of DEBOUNCE_CYCLES commits.
  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    commit_rise = 1'b0;
    commit_fall = 1'b0;
    unique case (state)
      S_LOW: begin
        if (din_s) begin
          state_nx = S_WAIT_HI;
          cnt_nx   = CW'(1);
        end
      end
      S_WAIT_HI: begin
        if (!din_s) begin
          state_nx = S_LOW;
          cnt_nx   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nx    = S_HIGH;
          cnt_nx      = '0;
          commit_rise = 1'b1;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      S_HIGH: begin
        if (!din_s) begin
          state_nx = S_WAIT_LO;
          cnt_nx   = CW'(1);
        end
      end
      S_WAIT_LO: begin
        if (din_s) begin
          state_nx = S_HIGH;
          cnt_nx   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nx    = S_LOW;
          cnt_nx      = '0;
          commit_fall = 1'b1;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: begin
        state_nx = S_LOW;
        cnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q           <= 1'b0;
      qbar        <= 1'b1;
      rise        <= 1'b0;
      fall        <= 1'b0;
      press_count <= '0;
    end else begin
      rise <= commit_rise;
      fall <= commit_fall;
      if (commit_rise) begin
        q           <= 1'b1;
        qbar        <= 1'b0;
        press_count <= press_count + 1'b1;
      end else if (commit_fall) begin
        q    <= 1'b0;
        qbar <= 1'b1;
      end
    end
  end

endmodule
